// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the generator and the lfsr7_checker receiver.
// State encoding, default width/taps and the single-step next() function.
package lfsr_pkg;

  localparam int LFSR_W = 7;
  localparam logic [LFSR_W:1] LFSR_TAPS = 7'b1100000;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  function automatic logic [LFSR_W:1] lfsr_next(
    input logic [LFSR_W:1] x,
    input logic [LFSR_W:1] taps
  );
    return {x[LFSR_W-1:1], ^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr7_next.sv
// Combinational single step of a Fibonacci LFSR, bits numbered [WIDTH:1].
// Used by the checker for both the reseed path and the flywheel path.
module lfsr7_next
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = LFSR_W,
  parameter logic [WIDTH:1]  TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH:1] x,
  output logic [WIDTH:1] y
);

  assign y = {x[WIDTH-1:1], ^(x & TAPS)};

endmodule

// File: rtl/lfsr7_checker.sv
// Receive-side LFSR checker: self-seeds, locks, flywheels and counts errors.
// Optional LFSR_CHK_PERIOD_EN adds period_len/period_valid measurement.
module lfsr7_checker
  import lfsr_pkg::*;
#(
  parameter int             WIDTH      = LFSR_W,
  parameter logic [WIDTH:1] TAPS       = LFSR_TAPS,
  parameter int             LOCK_COUNT = 4,
  parameter int             MISS_LIMIT = 3,
  parameter int             ERR_W      = 16,
  parameter int             CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH:1]   in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
`ifdef LFSR_CHK_PERIOD_EN
  output logic [WIDTH:0]   period_len,
  output logic             period_valid,
`endif
  output logic             zero_pulse
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(MISS_LIMIT + 1);

  chk_state_t     state;
  logic [WIDTH:1] expected;
  logic [MW-1:0]  match_cnt;
  logic [SW-1:0]  miss_cnt;

  logic [WIDTH:1] nxt_in;
  logic [WIDTH:1] nxt_exp;
  logic [MW-1:0]  match_nx;
  logic [SW-1:0]  miss_nx;
  logic           hit;
  logic           zero;
  logic           lock_enter;
  logic           lock_drop;

  lfsr7_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_reseed (
    .x (in_data),
    .y (nxt_in)
  );

  lfsr7_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_fly (
    .x (expected),
    .y (nxt_exp)
  );

  assign hit      = (in_data == expected);
  assign zero     = (in_data == '0);
  assign match_nx = match_cnt + MW'(1);
  assign miss_nx  = miss_cnt + SW'(1);

  assign lock_enter = in_valid && (state == VERIFY) && !zero
                   && hit && (match_nx == MW'(LOCK_COUNT));
  assign lock_drop  = in_valid && (state == LOCKED) && !hit
                   && (miss_nx == SW'(MISS_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      expected   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      zero_pulse <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      err_pulse  <= 1'b0;
      zero_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEARCH: begin
            if (zero) begin
              zero_pulse <= 1'b1;
            end else begin
              expected  <= nxt_in;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (zero) begin
              zero_pulse <= 1'b1;
              state      <= SEARCH;
            end else if (hit) begin
              expected  <= nxt_in;
              match_cnt <= match_nx;
              if (lock_enter) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              expected  <= nxt_in;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: never reseed from the line once locked.
            expected <= nxt_exp;
            if (~&word_count)
              word_count <= word_count + CNT_W'(1);
            if (zero)
              zero_pulse <= 1'b1;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (~&err_count)
                err_count <= err_count + ERR_W'(1);
              if (lock_drop) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_nx;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

`ifdef LFSR_CHK_PERIOD_EN
  logic [WIDTH:1] ref_word;
  logic [WIDTH:0] pcnt;
  logic [WIDTH:0] pcnt_nx;

  assign pcnt_nx = (&pcnt) ? pcnt : pcnt + (WIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (rst || lock_drop) begin
      ref_word     <= '0;
      pcnt         <= '0;
      period_len   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (lock_enter) begin
        ref_word <= in_data;
        pcnt     <= '0;
      end else if (in_valid && state == LOCKED) begin
        if (in_data == ref_word) begin
          period_len   <= pcnt_nx;
          period_valid <= 1'b1;
          pcnt         <= '0;
        end else begin
          pcnt <= pcnt_nx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr7_checker.sv
// Directed testbench for lfsr7_checker.
// Define LFSR_CHK_PERIOD_EN to also exercise period measurement.
module tb_lfsr7_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:1]  in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] word_count;
  logic        zero_pulse;
`ifdef LFSR_CHK_PERIOD_EN
  logic [7:0]  period_len;
  logic        period_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr7_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count),
`ifdef LFSR_CHK_PERIOD_EN
    .period_len   (period_len),
    .period_valid (period_valid),
`endif
    .zero_pulse (zero_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:1] nxt(input logic [7:1] x);
    return {x[6:1], x[7] ^ x[6]};
  endfunction

  task automatic send(input logic [7:1] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    send(7'h01); chk("pre1", locked, 0);
    send(7'h02); chk("pre2", locked, 0);
    send(7'h04); chk("pre3", locked, 0);
    send(7'h08); chk("pre4", locked, 0);
    send(7'h10); chk("lock", locked, 1);
  endtask

  initial begin
    logic [7:1] w;
    in_valid = 1'b0;
    in_data  = '0;

    // reset state
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_errp", err_pulse, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_zero", zero_pulse, 0);

    // 1: lock on 01..10
    lock_up();
    chk("t1_wc", word_count, 0);

    // 2: single corrupted word
    send(7'h30);
    chk("t2_errp", err_pulse, 1);
    chk("t2_errc", err_count, 1);
    chk("t2_lock", locked, 1);
    send(7'h41);
    chk("t2_errp2", err_pulse, 0);
    send(7'h03);
    chk("t2_errc2", err_count, 1);
    chk("t2_wc", word_count, 3);
    chk("t2_lock2", locked, 1);

    // 3: three misses drop lock, then relock
    do_reset();
    lock_up();
    send(7'h55); chk("t3_l1", locked, 1); chk("t3_e1", err_count, 1);
    send(7'h55); chk("t3_l2", locked, 1); chk("t3_e2", err_count, 2);
    send(7'h55); chk("t3_l3", locked, 0); chk("t3_e3", err_count, 3);
    chk("t3_wc", word_count, 3);
    lock_up();
    chk("t3_keep", err_count, 3);

    // 4: zero word in SEARCH
    do_reset();
    send(7'h00);
    chk("t4_zp", zero_pulse, 1);
    chk("t4_lock", locked, 0);
    idle(1);
    chk("t4_zp0", zero_pulse, 0);
    lock_up();

    // 5: gaps in a locked stream
    w = 7'h20;
    for (int g = 1; g <= 5; g++) begin
      send(w);
      w = nxt(w);
      chk("t5_wc", word_count, g);
      chk("t5_ep", err_pulse, 0);
      idle(g);
      chk("t5_wcg", word_count, g);
    end
    chk("t5_errc", err_count, 0);
    chk("t5_lock", locked, 1);
    send(7'h7f);
    chk("t5_bad", err_count, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_rl", locked, 0);
    chk("t5_re", err_count, 0);
    chk("t5_rw", word_count, 0);

`ifdef LFSR_CHK_PERIOD_EN
    // 6: period measurement over 260 words
    begin
      int pulses;
      do_reset();
      lock_up();
      pulses = 0;
      w = 7'h20;
      for (int k = 1; k <= 260; k++) begin
        send(w);
        w = nxt(w);
        if (period_valid) begin
          pulses++;
          chk("t6_len", period_len, 127);
          chk("t6_at", k, 127 * pulses);
        end
      end
      chk("t6_pulses", pulses, 2);
      chk("t6_errc", err_count, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
